// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the stopwatch generator.
// Holds the digit width, the largest legal digit value and the digit type.
package bcd_pkg;
  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BCD_MAX = 9;

  typedef logic [BCD_W-1:0] bcd_digit_t;
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of an up/down counter chain.
// Ports:
//   clk - clock, rising edge
//   clr - synchronous active-high clear
//   en  - step enable (the prescaler tick)
//   up  - direction: 1 increments, 0 decrements
//   ci  - carry/borrow in; the digit steps when en && ci
//   q   - current digit value, always 0..9
//   co  - carry/borrow out: q is 9 when counting up, 0 when counting down
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       up,
  input  logic       ci,
  output bcd_digit_t q,
  output logic       co
);

  bcd_digit_t dig_q;
  bcd_digit_t dig_d;

  // Out-of-range codes are folded back into 0..9 so the digit can never
  // sit on a non-BCD value even if one were somehow loaded.
  always_comb begin
    dig_d = dig_q;
    if (en && ci) begin
      if (up) begin
        dig_d = (dig_q >= bcd_digit_t'(BCD_MAX)) ? '0 : dig_q + bcd_digit_t'(1);
      end else begin
        dig_d = (dig_q == '0 || dig_q > bcd_digit_t'(BCD_MAX)) ?
                bcd_digit_t'(BCD_MAX) : dig_q - bcd_digit_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      dig_q <= '0;
    end else begin
      dig_q <= dig_d;
    end
  end

  assign q  = dig_q;
  assign co = up ? (dig_q == bcd_digit_t'(BCD_MAX)) : (dig_q == '0);

endmodule

// File: rtl/bcd_stopwatch_gen.sv
// Multi-digit BCD up/down stopwatch with prescaler and optional lap capture.
// Configuration macro: STOPWATCH_LAP_EN builds the lap capture registers;
// when undefined, lap is ignored and lap_d / lap_valid are tied to 0.
// Ports:
//   clk       - clock, rising edge
//   clr       - synchronous active-high clear, highest priority
//   go        - prescaler enable
//   up        - count direction (1 up, 0 down)
//   lap       - single-cycle capture strobe
//   d         - registered BCD count, digit 0 in bits [3:0]
//   lap_d     - registered captured count
//   lap_valid - one-cycle pulse after each capture
//   tick      - combinational step strobe
//   wrap      - registered one-cycle pulse when the count wraps
module bcd_stopwatch_gen
  import bcd_pkg::*;
#(
  parameter int unsigned NDIG = 3,
  parameter int unsigned DVSR = 10000000,
  parameter int unsigned PW   = $clog2(DVSR)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  go,
  input  logic                  up,
  input  logic                  lap,
  output logic [BCD_W*NDIG-1:0] d,
  output logic [BCD_W*NDIG-1:0] lap_d,
  output logic                  lap_valid,
  output logic                  tick,
  output logic                  wrap
);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;
  logic          wrap_q;
  logic          wrap_d;
  logic [NDIG:0] ci;
  logic [NDIG-1:0] co;

  assign tick = go && (cnt_q == PW'(DVSR - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (go) begin
      cnt_d = tick ? '0 : cnt_q + PW'(1);
    end
  end

  // ci[i] = tick AND co of every lower digit; ci[NDIG] therefore marks a
  // step that rolls the whole count over.
  assign ci[0] = tick;

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .clk (clk),
      .clr (clr),
      .en  (tick),
      .up  (up),
      .ci  (ci[i]),
      .q   (d[BCD_W*i +: BCD_W]),
      .co  (co[i])
    );
    assign ci[i+1] = ci[i] & co[i];
  end

  assign wrap_d = ci[NDIG];

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic [BCD_W*NDIG-1:0] lap_val_q;
  logic [BCD_W*NDIG-1:0] lap_val_d;
  logic                  lap_valid_q;
  logic                  lap_valid_d;

  // d is the pre-update register value here, so a step on the lap edge
  // is not captured.
  always_comb begin
    lap_val_d   = lap ? d : lap_val_q;
    lap_valid_d = lap;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      lap_val_q   <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_val_q   <= lap_val_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_d     = lap_val_q;
  assign lap_valid = lap_valid_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_d      = '0;
  assign lap_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_gen.sv
// Self-checking bench for bcd_stopwatch_gen (NDIG=3, DVSR=4).
// The reference model keeps the count as a plain integer modulo 10^NDIG
// and the prescaler as an integer phase; it is converted to BCD for checks.
module tb_bcd_stopwatch_gen;
  localparam int unsigned NDIG = 3;
  localparam int unsigned DVSR = 4;
  localparam int MOD = 1000;

  logic              clk = 1'b0;
  logic              clr = 1'b0;
  logic              go  = 1'b0;
  logic              up  = 1'b1;
  logic              lap = 1'b0;
  logic [4*NDIG-1:0] d;
  logic [4*NDIG-1:0] lap_d;
  logic              lap_valid;
  logic              tick;
  logic              wrap;

  bcd_stopwatch_gen #(.NDIG(NDIG), .DVSR(DVSR)) dut (
    .clk       (clk),
    .clr       (clr),
    .go        (go),
    .up        (up),
    .lap       (lap),
    .d         (d),
    .lap_d     (lap_d),
    .lap_valid (lap_valid),
    .tick      (tick),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_val   = 0;
  int m_phase = 0;
  int m_lapd  = 0;
  bit m_lapv  = 0;
  bit m_wrap  = 0;
  bit m_known = 0;

  bit obs_tick;
  int obs_ticks = 0;
  int obs_wraps = 0;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif

  function automatic logic [4*NDIG-1:0] to_bcd(input int v);
    logic [4*NDIG-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check tick before the edge, advance the model
  // on the edge, then check the registered outputs.
  task automatic cyc(input logic c, input logic g, input logic u, input logic l);
    bit et;
    clr = c; go = g; up = u; lap = l;
    #1;
    et = g && (m_phase == DVSR - 1);
    obs_tick = (tick === 1'b1);
    if (obs_tick) obs_ticks++;
    if (m_known) chk("tick", {31'b0, tick}, {31'b0, et});
    @(posedge clk);
    if (c) begin
      m_val = 0; m_phase = 0; m_lapd = 0; m_lapv = 0; m_wrap = 0; m_known = 1;
    end else begin
      m_lapv = LAP_ON && l;
      if (LAP_ON && l) m_lapd = m_val;
      m_wrap = 0;
      if (g) m_phase = (m_phase + 1) % DVSR;
      if (et) begin
        if (u) begin
          if (m_val == MOD - 1) begin m_val = 0; m_wrap = 1; end
          else m_val = m_val + 1;
        end else begin
          if (m_val == 0) begin m_val = MOD - 1; m_wrap = 1; end
          else m_val = m_val - 1;
        end
      end
    end
    #1;
    if (wrap === 1'b1) obs_wraps++;
    if (m_known) begin
      chk("d", 32'(d), 32'(to_bcd(m_val)));
      chk("wrap", {31'b0, wrap}, {31'b0, m_wrap});
      chk("lap_d", 32'(lap_d), 32'(to_bcd(m_lapd)));
      chk("lap_valid", {31'b0, lap_valid}, {31'b0, m_lapv});
    end
  endtask

  initial begin
    int n;
    logic [4*NDIG-1:0] held;

    // reset
    cyc(1, 0, 1, 0);
    cyc(1, 0, 1, 0);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_lap_d", 32'(lap_d), 32'h0);
    chk("rst_wrap", {31'b0, wrap}, 32'h0);

    // 40 cycles counting up
    obs_ticks = 0; obs_wraps = 0;
    for (int i = 0; i < 40; i++) cyc(0, 1, 1, 0);
    chk("ticks40", 32'(obs_ticks), 32'd10);
    chk("d_after40", 32'(d), 32'h010);
    chk("wraps40", 32'(obs_wraps), 32'd0);

    // preload 998, then 999 and the wrap to 000
    n = 0;
    while (m_val != 998 && n < 5000) begin cyc(0, 1, 1, 0); n++; end
    chk("reach998", 32'(d), 32'h998);
    n = 0;
    while (m_val != 999 && n < 10) begin cyc(0, 1, 1, 0); n++; end
    chk("d999", 32'(d), 32'h999);
    chk("wrap_at999", {31'b0, wrap}, 32'h0);
    n = 0;
    while (m_val != 0 && n < 10) begin cyc(0, 1, 1, 0); n++; end
    chk("d000", 32'(d), 32'h000);
    chk("wrap_at000", {31'b0, wrap}, 32'h1);
    cyc(0, 1, 1, 0);
    chk("wrap_pulse_end", {31'b0, wrap}, 32'h0);

    // count down through the wrap
    n = 0;
    while (m_val != 999 && n < 10) begin cyc(0, 1, 0, 0); n++; end
    chk("down_d999", 32'(d), 32'h999);
    chk("down_wrap", {31'b0, wrap}, 32'h1);
    obs_ticks = 0; n = 0;
    while (obs_ticks < 10 && n < 100) begin cyc(0, 1, 0, 0); n++; end
    cyc(0, 0, 0, 0);
    chk("down_d989", 32'(d), 32'h989);

    // lap on the same edge as a tick
    cyc(1, 0, 1, 0);
    n = 0;
    while (!(m_val == 123 && m_phase == DVSR - 1) && n < 1000) begin cyc(0, 1, 1, 0); n++; end
    cyc(0, 1, 1, 1);
    chk("lap_cap", 32'(lap_d), LAP_ON ? 32'h123 : 32'h0);
    chk("lap_step_d", 32'(d), 32'h124);
    chk("lap_valid1", {31'b0, lap_valid}, {31'b0, LAP_ON});
    cyc(0, 1, 1, 1);
    chk("lap_b2b", 32'(lap_d), LAP_ON ? 32'h124 : 32'h0);
    chk("lap_valid2", {31'b0, lap_valid}, {31'b0, LAP_ON});
    cyc(0, 1, 1, 0);
    chk("lap_valid_off", {31'b0, lap_valid}, 32'h0);

    // pause mid-period
    n = 0;
    while (m_phase != 1 && n < 8) begin cyc(0, 1, 1, 0); n++; end
    held = d;
    obs_ticks = 0;
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0);
    chk("pause_d", 32'(d), 32'(held));
    chk("pause_ticks", 32'(obs_ticks), 32'd0);
    n = 0; obs_tick = 0;
    while (!obs_tick && n < 8) begin cyc(0, 1, 1, 0); n++; end
    chk("resume_len", 32'(n), 32'd3);

    // clr with tick, lap and go high
    n = 0;
    while (m_phase != DVSR - 1 && n < 8) begin cyc(0, 1, 1, 0); n++; end
    cyc(1, 1, 1, 1);
    chk("clr_d", 32'(d), 32'h0);
    chk("clr_lap_d", 32'(lap_d), 32'h0);
    chk("clr_lap_valid", {31'b0, lap_valid}, 32'h0);
    chk("clr_wrap", {31'b0, wrap}, 32'h0);
    n = 0; obs_tick = 0;
    while (!obs_tick && n < 8) begin cyc(0, 1, 1, 0); n++; end
    chk("clr_first_tick", 32'(n), 32'd4);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 31) != 0) ? up : ~up, ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
